// File: rtl/float_pkg.sv
// Shared widths, class-bit positions and lane-slicing helpers for the float unpacker.
package float_pkg;

  localparam int unsigned CLS_ZERO = 0;
  localparam int unsigned CLS_SUB  = 1;
  localparam int unsigned CLS_INF  = 2;
  localparam int unsigned CLS_NAN  = 3;
  localparam int unsigned CLS_W    = 4;

  function automatic int unsigned fw(input int unsigned exp_w, input int unsigned man_w);
    return exp_w + man_w + 1;
  endfunction

  function automatic int unsigned exp_out_w(input int unsigned exp_w);
    return exp_w + 2;
  endfunction

  function automatic int unsigned man_out_w(input int unsigned man_w);
    return man_w + 3;
  endfunction

  function automatic int unsigned lzc_w(input int unsigned man_w);
    return $clog2(man_w + 1);
  endfunction

  // Bit offset of a lane inside a flattened multi-lane bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/float_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module float_lzc
  import float_pkg::*;
#(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned CNT_W = lzc_w(WIDTH)
) (
  input  logic [WIDTH-1:0] din_i,
  output logic [CNT_W-1:0] cnt_c_o
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    cnt_c_o = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (din_i[i]) begin
        cnt_c_o = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/float_unpack_pipe.sv
// Two-stage multi-lane float unpacker: decode/classify, then optional subnormal
// normalisation, with valid/ready handshakes on both sides.
module float_unpack_pipe
  import float_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 7,
  parameter int unsigned LANES     = 4,
  parameter int unsigned NORMALIZE = 0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        flush,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [LANES*fw(EXP_WIDTH, MAN_WIDTH)-1:0]   in_data,
  input  logic [LANES-1:0]                            in_mask,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [LANES-1:0]                            out_sign,
  output logic [LANES*exp_out_w(EXP_WIDTH)-1:0]       out_exp,
  output logic [LANES*man_out_w(MAN_WIDTH)-1:0]       out_man,
  output logic [LANES*CLS_W-1:0]                      out_class
);

  localparam int unsigned FW_W   = fw(EXP_WIDTH, MAN_WIDTH);
  localparam int unsigned EXO_W  = exp_out_w(EXP_WIDTH);
  localparam int unsigned MNO_W  = man_out_w(MAN_WIDTH);
  localparam int unsigned LZ_W   = lzc_w(MAN_WIDTH);
  localparam int unsigned SIG_W  = MAN_WIDTH + 1;
  localparam int unsigned SH_W   = LZ_W + 1;

  // Stage 1 state
  logic                               s1_valid_q, s1_valid_d;
  logic [LANES-1:0]                   s1_sign_q,  s1_sign_d;
  logic [LANES-1:0][EXP_WIDTH-1:0]    s1_exp_q,   s1_exp_d;
  logic [LANES-1:0]                   s1_hid_q,   s1_hid_d;
  logic [LANES-1:0][MAN_WIDTH-1:0]    s1_frac_q,  s1_frac_d;
  logic [LANES-1:0][CLS_W-1:0]        s1_cls_q,   s1_cls_d;
  logic [LANES-1:0][LZ_W-1:0]         s1_lz_q,    s1_lz_d;

  // Stage 2 state (drives the outputs directly)
  logic                               s2_valid_q, s2_valid_d;
  logic [LANES-1:0]                   s2_sign_q,  s2_sign_d;
  logic [LANES-1:0][EXO_W-1:0]        s2_exp_q,   s2_exp_d;
  logic [LANES-1:0][MNO_W-1:0]        s2_man_q,   s2_man_d;
  logic [LANES-1:0][CLS_W-1:0]        s2_cls_q,   s2_cls_d;

  // Combinational decode of the incoming beat
  logic [LANES-1:0]                   dec_sign_c;
  logic [LANES-1:0][EXP_WIDTH-1:0]    dec_field_c;
  logic [LANES-1:0][EXP_WIDTH-1:0]    dec_exp_c;
  logic [LANES-1:0]                   dec_hid_c;
  logic [LANES-1:0][MAN_WIDTH-1:0]    dec_frac_c;
  logic [LANES-1:0][CLS_W-1:0]        dec_cls_c;
  logic [LANES-1:0][LZ_W-1:0]         lz_c;

  logic s2_load_c;
  logic s1_load_c;

  // A stage accepts when empty or when the stage after it is accepting.
  assign s2_load_c = !s2_valid_q || out_ready;
  assign s1_load_c = !s1_valid_q || s2_load_c;
  assign in_ready  = s1_load_c;

  always_comb begin
    dec_sign_c  = '0;
    dec_field_c = '0;
    dec_exp_c   = '0;
    dec_hid_c   = '0;
    dec_frac_c  = '0;
    dec_cls_c   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      dec_sign_c[i]  = in_data[lane_lsb(i, FW_W) + FW_W - 1];
      dec_field_c[i] = in_data[lane_lsb(i, FW_W) + MAN_WIDTH +: EXP_WIDTH];
      dec_frac_c[i]  = in_data[lane_lsb(i, FW_W) +: MAN_WIDTH];
      dec_hid_c[i]   = |dec_field_c[i];
      dec_exp_c[i]   = dec_hid_c[i] ? dec_field_c[i] : EXP_WIDTH'(1);
      dec_cls_c[i][CLS_ZERO] = !dec_hid_c[i] && !(|dec_frac_c[i]);
      dec_cls_c[i][CLS_SUB]  = !dec_hid_c[i] &&  (|dec_frac_c[i]);
      dec_cls_c[i][CLS_INF]  = (&dec_field_c[i]) && !(|dec_frac_c[i]);
      dec_cls_c[i][CLS_NAN]  = (&dec_field_c[i]) &&  (|dec_frac_c[i]);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lzc
    float_lzc #(
      .WIDTH (MAN_WIDTH),
      .CNT_W (LZ_W)
    ) u_lzc (
      .din_i   (dec_frac_c[g]),
      .cnt_c_o (lz_c[g])
    );
  end

  // Stage 1 next state; masked lanes load all-zero fields.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_hid_d   = s1_hid_q;
    s1_frac_d  = s1_frac_q;
    s1_cls_d   = s1_cls_q;
    s1_lz_d    = s1_lz_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_load_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (in_mask[i]) begin
            s1_sign_d[i] = dec_sign_c[i];
            s1_exp_d[i]  = dec_exp_c[i];
            s1_hid_d[i]  = dec_hid_c[i];
            s1_frac_d[i] = dec_frac_c[i];
            s1_cls_d[i]  = dec_cls_c[i];
            s1_lz_d[i]   = lz_c[i];
          end else begin
            s1_sign_d[i] = 1'b0;
            s1_exp_d[i]  = '0;
            s1_hid_d[i]  = 1'b0;
            s1_frac_d[i] = '0;
            s1_cls_d[i]  = '0;
            s1_lz_d[i]   = '0;
          end
        end
      end
    end
  end

  // Stage 2 next state; only subnormals are ever shifted.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_exp_d   = s2_exp_q;
    s2_man_d   = s2_man_q;
    s2_cls_d   = s2_cls_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          s2_sign_d[i] = s1_sign_q[i];
          s2_cls_d[i]  = s1_cls_q[i];
          if ((NORMALIZE != 0) && s1_cls_q[i][CLS_SUB]) begin
            s2_man_d[i] = {2'b00, SIG_W'({1'b0, s1_frac_q[i]} << (SH_W'(s1_lz_q[i]) + SH_W'(1)))};
            s2_exp_d[i] = EXO_W'(0) - EXO_W'(s1_lz_q[i]);
          end else begin
            s2_man_d[i] = {2'b00, s1_hid_q[i], s1_frac_q[i]};
            s2_exp_d[i] = EXO_W'(s1_exp_q[i]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= '0;
      s1_exp_q   <= '0;
      s1_hid_q   <= '0;
      s1_frac_q  <= '0;
      s1_cls_q   <= '0;
      s1_lz_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= '0;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
      s2_cls_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_hid_q   <= s1_hid_d;
      s1_frac_q  <= s1_frac_d;
      s1_cls_q   <= s1_cls_d;
      s1_lz_q    <= s1_lz_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_man_q   <= s2_man_d;
      s2_cls_q   <= s2_cls_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_exp   = s2_exp_q;
  assign out_man   = s2_man_q;
  assign out_class = s2_cls_q;

endmodule

// File: tb/tb_float_unpack_pipe.sv
// Directed bench for float_unpack_pipe; runs NORMALIZE=0 and NORMALIZE=1 instances side by side.
module tb_float_unpack_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_data = '0;
  logic [3:0]  in_mask = '0;

  logic        rdy0, rdy1, ov0, ov1;
  logic [3:0]  sg0, sg1;
  logic [39:0] e0, e1, m0, m1;
  logic [15:0] c0, c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_unpack_pipe #(.EXP_WIDTH(8), .MAN_WIDTH(7), .LANES(4), .NORMALIZE(0)) dut_n0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_mask(in_mask), .out_valid(ov0), .out_ready(out_ready),
    .out_sign(sg0), .out_exp(e0), .out_man(m0), .out_class(c0)
  );

  float_unpack_pipe #(.EXP_WIDTH(8), .MAN_WIDTH(7), .LANES(4), .NORMALIZE(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_mask(in_mask), .out_valid(ov1), .out_ready(out_ready),
    .out_sign(sg1), .out_exp(e1), .out_man(m1), .out_class(c1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Push one beat into an empty pipe and check the two-cycle latency.
  task automatic single_beat(input logic [63:0] d, input logic [3:0] m);
    in_valid = 1'b1; in_data = d; in_mask = m; out_ready = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL beat_in_ready: got %b expected 1", rdy0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; in_mask = '0;
    checks++;
    if (ov0 !== 1'b0) begin
      errors++; $display("FAIL latency_early: out_valid got %b expected 0", ov0);
    end
    @(posedge clk); #1;
    checks++;
    if (ov0 !== 1'b1 || ov1 !== 1'b1) begin
      errors++; $display("FAIL latency_2: out_valid got %b/%b expected 1/1", ov0, ov1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({ov0, ov1} !== 2'b00) begin
      errors++; $display("FAIL reset_valid: got %b expected 00", {ov0, ov1});
    end
    checks++;
    if ({sg0, e0, m0, c0} !== '0 || {sg1, e1, m1, c1} !== '0) begin
      errors++; $display("FAIL reset_data: got e0=%h m0=%h c0=%h e1=%h expected all 0", e0, m0, c0, e1);
    end
    checks++;
    if ({rdy0, rdy1} !== 2'b11) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 11", {rdy0, rdy1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    single_beat(64'h0000_0000_0000_3F80, 4'b0001);
    checks++;
    if (sg0[0] !== 1'b0 || e0[9:0] !== 10'd127 || m0[9:0] !== 10'h080 || c0[3:0] !== 4'b0000) begin
      errors++; $display("FAIL basic_lane0: got s=%b e=%h m=%h c=%b expected s=0 e=07f m=080 c=0000",
                         sg0[0], e0[9:0], m0[9:0], c0[3:0]);
    end
    checks++;
    if (sg0[3:1] !== '0 || e0[39:10] !== '0 || m0[39:10] !== '0 || c0[15:4] !== '0) begin
      errors++; $display("FAIL basic_upper_lanes: got e=%h m=%h c=%h expected 0", e0[39:10], m0[39:10], c0[15:4]);
    end
    checks++;
    if (e1[9:0] !== 10'd127 || m1[9:0] !== 10'h080) begin
      errors++; $display("FAIL basic_norm1: got e=%h m=%h expected e=07f m=080", e1[9:0], m1[9:0]);
    end
    idle(2);
  endtask

  task automatic test_subnormal();
    logic [3:0] xs;
    logic [9:0] xe0 [4];
    logic [9:0] xm0 [4];
    logic [9:0] xe1 [4];
    logic [9:0] xm1 [4];
    xs  = 4'b1000;
    xe0 = '{10'h001, 10'h001, 10'h001, 10'h001};
    xm0 = '{10'h001, 10'h040, 10'h005, 10'h003};
    xe1 = '{10'h3FA, 10'h000, 10'h3FC, 10'h3FB};
    xm1 = '{10'h080, 10'h080, 10'h0A0, 10'h0C0};
    single_beat(64'h8003_0005_0040_0001, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sg0[i] !== xs[i] || e0[i*10 +: 10] !== xe0[i] || m0[i*10 +: 10] !== xm0[i] || c0[i*4 +: 4] !== 4'b0010) begin
        errors++; $display("FAIL sub_norm0_lane%0d: got s=%b e=%h m=%h c=%b expected s=%b e=%h m=%h c=0010",
                           i, sg0[i], e0[i*10 +: 10], m0[i*10 +: 10], c0[i*4 +: 4], xs[i], xe0[i], xm0[i]);
      end
      checks++;
      if (sg1[i] !== xs[i] || e1[i*10 +: 10] !== xe1[i] || m1[i*10 +: 10] !== xm1[i] || c1[i*4 +: 4] !== 4'b0010) begin
        errors++; $display("FAIL sub_norm1_lane%0d: got s=%b e=%h m=%h c=%b expected s=%b e=%h m=%h c=0010",
                           i, sg1[i], e1[i*10 +: 10], m1[i*10 +: 10], c1[i*4 +: 4], xs[i], xe1[i], xm1[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_special();
    logic [3:0] xs;
    logic [9:0] xe [4];
    logic [9:0] xm [4];
    logic [3:0] xc [4];
    xs = 4'b1001;
    xe = '{10'h001, 10'h0FF, 10'h0FF, 10'h0FF};
    xm = '{10'h000, 10'h080, 10'h0C1, 10'h081};
    xc = '{4'b0001, 4'b0100, 4'b1000, 4'b1000};
    single_beat(64'hFF81_7FC1_7F80_8000, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sg0[i] !== xs[i] || e0[i*10 +: 10] !== xe[i] || m0[i*10 +: 10] !== xm[i] || c0[i*4 +: 4] !== xc[i]) begin
        errors++; $display("FAIL special_lane%0d: got s=%b e=%h m=%h c=%b expected s=%b e=%h m=%h c=%b",
                           i, sg0[i], e0[i*10 +: 10], m0[i*10 +: 10], c0[i*4 +: 4], xs[i], xe[i], xm[i], xc[i]);
      end
      checks++;
      if (e1[i*10 +: 10] !== xe[i] || m1[i*10 +: 10] !== xm[i] || c1[i*4 +: 4] !== xc[i]) begin
        errors++; $display("FAIL special_norm1_lane%0d: got e=%h m=%h c=%b expected e=%h m=%h c=%b",
                           i, e1[i*10 +: 10], m1[i*10 +: 10], c1[i*4 +: 4], xe[i], xm[i], xc[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_mask();
    logic [3:0] msk;
    logic [3:0] xs;
    logic [9:0] xe [4];
    logic [9:0] xm [4];
    logic [3:0] xc [4];
    msk = 4'b1010;
    xs  = 4'b1000;
    xe  = '{10'h000, 10'h0FF, 10'h000, 10'h0FF};
    xm  = '{10'h000, 10'h080, 10'h000, 10'h081};
    xc  = '{4'b0000, 4'b0100, 4'b0000, 4'b1000};
    single_beat(64'hFF81_7FC1_7F80_8000, msk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sg0[i] !== xs[i] || e0[i*10 +: 10] !== xe[i] || m0[i*10 +: 10] !== xm[i] || c0[i*4 +: 4] !== xc[i]) begin
        errors++; $display("FAIL mask_lane%0d: got s=%b e=%h m=%h c=%b expected s=%b e=%h m=%h c=%b",
                           i, sg0[i], e0[i*10 +: 10], m0[i*10 +: 10], c0[i*4 +: 4], xs[i], xe[i], xm[i], xc[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    bit m_s1, m_s2, n_s1, n_s2, exp_ir, s2_acc, s1_acc, in_fire, out_fire;
    int sent, rcv, cyc;
    m_s1 = 1'b0; m_s2 = 1'b0; sent = 0; rcv = 0;
    for (cyc = 0; cyc < 80 && rcv < 8; cyc++) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid  = (sent < 8);
      in_data   = {48'h0, 16'h3F80 + 16'(sent)};
      in_mask   = 4'b0001;
      #1;
      exp_ir = !m_s1 || !m_s2 || out_ready;
      checks++;
      if (ov0 !== m_s2) begin
        errors++; $display("FAIL b2b_out_valid cyc%0d: got %b expected %b", cyc, ov0, m_s2);
      end
      checks++;
      if (rdy0 !== exp_ir) begin
        errors++; $display("FAIL b2b_in_ready cyc%0d: got %b expected %b", cyc, rdy0, exp_ir);
      end
      if (m_s2) begin
        checks++;
        if (m0[9:0] !== 10'h080 + 10'(rcv) || e0[9:0] !== 10'd127) begin
          errors++; $display("FAIL b2b_data cyc%0d: got m=%h e=%h expected m=%h e=07f",
                             cyc, m0[9:0], e0[9:0], 10'h080 + 10'(rcv));
        end
      end
      in_fire  = in_valid && exp_ir;
      out_fire = m_s2 && out_ready;
      s2_acc   = !m_s2 || out_ready;
      n_s2     = s2_acc ? m_s1 : m_s2;
      s1_acc   = !m_s1 || s2_acc;
      n_s1     = s1_acc ? in_valid : m_s1;
      m_s1 = n_s1; m_s2 = n_s2;
      if (out_fire) rcv++;
      if (in_fire) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b1;
    checks++;
    if (rcv != 8 || sent != 8) begin
      errors++; $display("FAIL b2b_count: got sent=%0d received=%0d expected 8/8", sent, rcv);
    end
    idle(3);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mask = 4'b0001; in_data = 64'h3F81;
    @(posedge clk); #1;
    in_data = 64'h3F82;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (ov0 !== 1'b1 || rdy0 !== 1'b0) begin
      errors++; $display("FAIL flush_full: got out_valid=%b in_ready=%b expected 1/0", ov0, rdy0);
    end
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    checks++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got out_valid=%b/%b expected 0/0", ov0, ov1);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ov0 !== 1'b0) begin
        errors++; $display("FAIL flush_no_leak%0d: got out_valid=%b expected 0", k, ov0);
      end
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h3F83;
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL flush_in_ready: got %b expected 1", rdy0);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov0 !== 1'b0) begin
        errors++; $display("FAIL flush_drop%0d: got out_valid=%b expected 0", k, ov0);
      end
      @(posedge clk); #1;
    end
    single_beat(64'h3F84, 4'b0001);
    checks++;
    if (m0[9:0] !== 10'h084 || e0[9:0] !== 10'd127) begin
      errors++; $display("FAIL flush_after: got m=%h e=%h expected m=084 e=07f", m0[9:0], e0[9:0]);
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    single_beat(64'h3F85, 4'b0001);
    out_ready = 1'b0; in_valid = 1'b1; in_mask = 4'b0001; in_data = 64'h3F86;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
      errors++; $display("FAIL arst_valid: got %b/%b expected 0/0", ov0, ov1);
    end
    checks++;
    if ({sg0, e0, m0, c0} !== '0 || {sg1, e1, m1, c1} !== '0) begin
      errors++; $display("FAIL arst_data: got e0=%h m0=%h c0=%h expected all 0", e0, m0, c0);
    end
    in_valid = 1'b0; in_data = '0; in_mask = '0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ov0 !== 1'b0) begin
        errors++; $display("FAIL arst_no_partial%0d: got out_valid=%b expected 0", k, ov0);
      end
      @(posedge clk); #1;
    end
    single_beat(64'h3F87, 4'b0001);
    checks++;
    if (m0[9:0] !== 10'h087 || e0[9:0] !== 10'd127 || c0[3:0] !== 4'b0000) begin
      errors++; $display("FAIL arst_resume: got m=%h e=%h c=%b expected m=087 e=07f c=0000", m0[9:0], e0[9:0], c0[3:0]);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_subnormal();
    test_special();
    test_mask();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
